// File: rtl/alu_pkg.sv
// Shared ALU opcodes and multiplier state type, used by alu and alu_mul_seq.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_NONE = 4'b0000,
      OP_ADD  = 4'b0110,
      OP_SLL  = 4'b1001,
      OP_SRL  = 4'b1011
   } alu_op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADD,
      ST_SHL,
      ST_SHR,
      ST_DONE
   } mul_state_e;

   localparam int unsigned MUL_WIDTH     = 16;
   localparam logic [4:0]  MUL_LAST_ITER = 5'd15;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Request/result bundle of the sequential multiplier; slave is the multiplier side.
interface alu_mul_seq_if;
   logic        start;
   logic [15:0] mcand;
   logic [15:0] mplier;
   logic        busy;
   logic        done;
   logic [15:0] product;
   logic        ovf;

   modport master (
      output start, mcand, mplier,
      input  busy, done, product, ovf
   );

   modport slave (
      input  start, mcand, mplier,
      output busy, done, product, ovf
   );
endinterface

// File: rtl/alu.sv
// 16-bit ALU with operand preprocessing; supports NONE, ADD, SLL and SRL.
module alu
   import alu_pkg::*;
(
   input  logic [15:0] opr_a,
   input  logic [15:0] opr_b,
   input  alu_op_e     op,
   input  logic        neg_a,
   input  logic        inv_b,
   input  logic        slbi_shift8,
   output logic [15:0] result,
   output logic        cf,
   output logic        zf
);

   logic [15:0] a;
   logic [15:0] b;
   logic [16:0] sum;
   logic [31:0] wide;

   always_comb begin
      a = neg_a ? ((~opr_a) + 16'd1) : opr_a;
      b = inv_b ? ~opr_b : opr_b;
      if (slbi_shift8) begin
         b = {b[7:0], 8'h00};
      end
      sum    = {1'b0, a} + {1'b0, b};
      wide   = '0;
      result = '0;
      cf     = 1'b0;
      // Shifts run in a 32-bit window so the last bit shifted out lands next to the result.
      case (op)
         OP_ADD: begin
            result = sum[15:0];
            cf     = sum[16];
         end
         OP_SLL: begin
            wide   = {16'h0000, a} << b[3:0];
            result = wide[15:0];
            cf     = wide[16];
         end
         OP_SRL: begin
            wide   = {a, 16'h0000} >> b[3:0];
            result = wide[31:16];
            cf     = wide[15];
         end
         default: begin
            result = '0;
            cf     = 1'b0;
         end
      endcase
   end

   assign zf = (result == '0);

endmodule

// File: rtl/alu_mul_seq.sv
// Sequential 16x16 shift-and-add multiplier that sequences an external ALU.
// Define ALU_MUL_EARLY_EXIT_EN to finish as soon as the remaining multiplier is zero.
module alu_mul_seq
   import alu_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   alu_mul_seq_if.slave bus,
   output logic [15:0]  alu_opr_a,
   output logic [15:0]  alu_opr_b,
   output alu_op_e      alu_op,
   output logic         alu_neg_a,
   output logic         alu_inv_b,
   output logic         alu_slbi_shift8,
   input  logic [15:0]  alu_out,
   input  logic         alu_cf,
   input  logic         alu_zf
);

   mul_state_e  state;
   logic [15:0] acc;
   logic [15:0] mc;
   logic [15:0] mp;
   logic [4:0]  cnt;
   logic        lost;
   logic        busy_q;
   logic        done_q;
   logic [15:0] product_q;
   logic        ovf_q;
   logic        last_iter;

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.product     = product_q;
   assign bus.ovf         = ovf_q;
   assign alu_neg_a       = 1'b0;
   assign alu_inv_b       = 1'b0;
   assign alu_slbi_shift8 = 1'b0;

`ifdef ALU_MUL_EARLY_EXIT_EN
   always_comb begin
      last_iter = (cnt == MUL_LAST_ITER) || alu_zf;
   end
`else
   logic unused_zf;
   assign unused_zf = alu_zf;

   always_comb begin
      last_iter = (cnt == MUL_LAST_ITER);
   end
`endif

   // ALU operands are registered on entry to each state, so alu_out is valid throughout it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         acc       <= '0;
         mc        <= '0;
         mp        <= '0;
         cnt       <= '0;
         lost      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         product_q <= '0;
         ovf_q     <= 1'b0;
         alu_op    <= OP_NONE;
         alu_opr_a <= '0;
         alu_opr_b <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  mc        <= bus.mcand;
                  mp        <= bus.mplier;
                  acc       <= '0;
                  lost      <= 1'b0;
                  ovf_q     <= 1'b0;
                  cnt       <= '0;
                  busy_q    <= 1'b1;
                  alu_op    <= OP_ADD;
                  alu_opr_a <= '0;
                  alu_opr_b <= bus.mcand;
                  state     <= ST_ADD;
               end
            end
            ST_ADD: begin
               if (mp[0]) begin
                  acc   <= alu_out;
                  ovf_q <= ovf_q | alu_cf;
               end
               alu_op    <= OP_SLL;
               alu_opr_a <= mc;
               alu_opr_b <= 16'd1;
               state     <= ST_SHL;
            end
            ST_SHL: begin
               mc        <= alu_out;
               lost      <= lost | mc[15];
               alu_op    <= OP_SRL;
               alu_opr_a <= mp;
               alu_opr_b <= 16'd1;
               state     <= ST_SHR;
            end
            ST_SHR: begin
               mp  <= alu_out;
               cnt <= cnt + 5'd1;
               // A lost multiplicand bit still to be weighted by a remaining multiplier bit.
               if (lost && (alu_out != '0)) begin
                  ovf_q <= 1'b1;
               end
               if (last_iter) begin
                  done_q    <= 1'b1;
                  product_q <= acc;
                  alu_op    <= OP_NONE;
                  alu_opr_a <= '0;
                  alu_opr_b <= '0;
                  state     <= ST_DONE;
               end else begin
                  alu_op    <= OP_ADD;
                  alu_opr_a <= acc;
                  alu_opr_b <= mc;
                  state     <= ST_ADD;
               end
            end
            ST_DONE: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= ST_IDLE;
            end
            default: begin
               done_q    <= 1'b0;
               busy_q    <= 1'b0;
               alu_op    <= OP_NONE;
               alu_opr_a <= '0;
               alu_opr_b <= '0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq wired to the real alu; follows ALU_MUL_EARLY_EXIT_EN for latency.
module tb_alu_mul_seq;
   import alu_pkg::*;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] prod;
      logic        ovf;
   } vec_t;

   typedef struct {
      logic [15:0] prod;
      logic        ovf;
      int unsigned done_cyc;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [15:0] alu_opr_a;
   logic [15:0] alu_opr_b;
   alu_op_e     alu_op;
   logic        alu_neg_a;
   logic        alu_inv_b;
   logic        alu_slbi_shift8;
   logic [15:0] alu_out;
   logic        alu_cf;
   logic        alu_zf;

   int unsigned checks   = 0;
   int unsigned failures = 0;
   int unsigned cyc      = 0;
   exp_t        sb[$];
   exp_t        mon_e;
   vec_t        vecs[12];

   alu_mul_seq_if bus ();

   alu_mul_seq dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .bus             (bus),
      .alu_opr_a       (alu_opr_a),
      .alu_opr_b       (alu_opr_b),
      .alu_op          (alu_op),
      .alu_neg_a       (alu_neg_a),
      .alu_inv_b       (alu_inv_b),
      .alu_slbi_shift8 (alu_slbi_shift8),
      .alu_out         (alu_out),
      .alu_cf          (alu_cf),
      .alu_zf          (alu_zf)
   );

   alu u_alu (
      .opr_a       (alu_opr_a),
      .opr_b       (alu_opr_b),
      .op          (alu_op),
      .neg_a       (alu_neg_a),
      .inv_b       (alu_inv_b),
      .slbi_shift8 (alu_slbi_shift8),
      .result      (alu_out),
      .cf          (alu_cf),
      .zf          (alu_zf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Iterations the multiplier executes for a given multiplier operand.
   function automatic int unsigned exp_iters(input logic [15:0] b);
      int unsigned n = 1;
      for (int unsigned i = 0; i < 16; i++) begin
         if (b[i]) n = i + 1;
      end
`ifdef ALU_MUL_EARLY_EXIT_EN
      return n;
`else
      return 16;
`endif
   endfunction

   always @(negedge clk) begin
      if (rst_n && bus.done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("product", 32'(bus.product), 32'(mon_e.prod));
            check("ovf", 32'(bus.ovf), 32'(mon_e.ovf));
            check("done_cycle", cyc, mon_e.done_cyc);
         end
      end
   end

   task automatic wait_done(input string name);
      int unsigned k = 0;
      while (!bus.done && k < 64) begin
         @(negedge clk);
         k++;
      end
      if (!bus.done) check({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] p, input logic o, input string name);
      exp_t e;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.mcand  = a;
      bus.mplier = b;
      @(negedge clk);
      bus.start  = 1'b0;
      bus.mcand  = 16'($urandom);
      bus.mplier = 16'($urandom);
      e.prod     = p;
      e.ovf      = o;
      e.done_cyc = cyc + 3 * exp_iters(b);
      sb.push_back(e);
      check({name, "_busy"}, 32'(bus.busy), 32'd1);
      wait_done(name);
      @(negedge clk);
      check({name, "_busy_clr"}, 32'(bus.busy), 32'd0);
      check({name, "_done_pulse"}, 32'(bus.done), 32'd0);
   endtask

   task automatic check_zero(input string name);
      check({name, "_busy"}, 32'(bus.busy), 32'd0);
      check({name, "_done"}, 32'(bus.done), 32'd0);
      check({name, "_product"}, 32'(bus.product), 32'd0);
      check({name, "_ovf"}, 32'(bus.ovf), 32'd0);
      check({name, "_alu_op"}, 32'(alu_op), 32'd0);
      check({name, "_opr_a"}, 32'(alu_opr_a), 32'd0);
      check({name, "_opr_b"}, 32'(alu_opr_b), 32'd0);
   endtask

   initial begin
      exp_t        e;
      int unsigned c0;
      int unsigned n1;
      int unsigned n2;

      vecs[0]  = '{16'h0003, 16'h0005, 16'h000F, 1'b0};
      vecs[1]  = '{16'h0100, 16'h0100, 16'h0000, 1'b1};
      vecs[2]  = '{16'hFFFF, 16'hFFFF, 16'h0001, 1'b1};
      vecs[3]  = '{16'h1234, 16'h0000, 16'h0000, 1'b0};
      vecs[4]  = '{16'h00FF, 16'h0101, 16'hFFFF, 1'b0};
      vecs[5]  = '{16'h0100, 16'h00FF, 16'hFF00, 1'b0};
      vecs[6]  = '{16'h8000, 16'h0002, 16'h0000, 1'b1};
      vecs[7]  = '{16'h0002, 16'h8000, 16'h0000, 1'b1};
      vecs[8]  = '{16'h0001, 16'hFFFF, 16'hFFFF, 1'b0};
      vecs[9]  = '{16'h1234, 16'h5678, 16'h0060, 1'b1};
      vecs[10] = '{16'h0003, 16'h5555, 16'hFFFF, 1'b0};
      vecs[11] = '{16'h0002, 16'h8001, 16'h0002, 1'b1};

      rst_n      = 1'b0;
      bus.start  = 1'b0;
      bus.mcand  = '0;
      bus.mplier = '0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;

      for (int unsigned i = 0; i < 12; i++) begin
         run_mul(vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].ovf, $sformatf("vec%0d", i));
      end

      // start held high across a whole multiply with new operands after accept
      n1 = exp_iters(16'h0005);
      n2 = exp_iters(16'h0009);
      @(negedge clk);
      bus.start  = 1'b1;
      bus.mcand  = 16'h0003;
      bus.mplier = 16'h0005;
      @(negedge clk);
      c0 = cyc;
      bus.mcand  = 16'h0007;
      bus.mplier = 16'h0009;
      e.prod = 16'h000F; e.ovf = 1'b0; e.done_cyc = c0 + 3 * n1;
      sb.push_back(e);
      e.prod = 16'h003F; e.ovf = 1'b0; e.done_cyc = c0 + 3 * n1 + 2 + 3 * n2;
      sb.push_back(e);
      check("held_busy", 32'(bus.busy), 32'd1);
      wait_done("held1");
      @(negedge clk);
      check("held_idle", 32'(bus.busy), 32'd0);
      @(negedge clk);
      check("held_reaccept", 32'(bus.busy), 32'd1);
      bus.start = 1'b0;
      wait_done("held2");
      @(negedge clk);
      check("held_busy_clr", 32'(bus.busy), 32'd0);

      // asynchronous reset in the middle of 7*9, then an immediate new request
      @(negedge clk);
      bus.start  = 1'b1;
      bus.mcand  = 16'h0007;
      bus.mplier = 16'h0009;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (19) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_zero("abort");
      @(negedge clk);
      check("abort_hold_done", 32'(bus.done), 32'd0);
      check("abort_hold_busy", 32'(bus.busy), 32'd0);
      rst_n      = 1'b1;
      bus.start  = 1'b1;
      bus.mcand  = 16'h0007;
      bus.mplier = 16'h0009;
      @(negedge clk);
      bus.start = 1'b0;
      check("post_reset_accept", 32'(bus.busy), 32'd1);
      e.prod = 16'h003F; e.ovf = 1'b0; e.done_cyc = cyc + 3 * n2;
      sb.push_back(e);
      wait_done("post_reset");
      @(negedge clk);
      check("post_reset_busy_clr", 32'(bus.busy), 32'd0);

      repeat (4) @(negedge clk);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/alu_mul_seq.md
ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; all other ports are synchronous to clk.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  multiply request; sampled only in IDLE.
REQ-005 mcand  input  16  unsigned multiplicand, captured on accept.
REQ-006 mplier  input  16  unsigned multiplier, captured on accept.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 done  output  1  one-cycle pulse; product/ovf valid.
REQ-009 product  output  16  low 16 bits of mcand*mplier, held until next accept.
REQ-010 ovf  output  1  high when true 32-bit product > 0xFFFF, held with product.
REQ-011 alu_opr_a, alu_opr_b  output  16 each  ALU operands.
REQ-012 alu_op  output  4  ALU operation code.
REQ-013 alu_neg_a, alu_inv_b, alu_slbi_shift8  output  1 each  ALU preprocessing controls, always 0.
REQ-014 alu_out  input  16; alu_cf, alu_zf  input  1 each  ALU result and flags.

Function
REQ-015 SHALL be a state machine: IDLE, ADD, SHL, SHR, DONE; internal acc, mc, mp (16 bits each), lost flag, 5-bit iteration counter.
REQ-016 IDLE: start=1 accepts -> mc<=mcand, mp<=mplier, acc<=0, lost<=0, ovf<=0, counter<=0, next ADD; start=0 stays.
REQ-017 ADD: alu_op=0110 (ADD), A=acc, B=mc; if mp[0]=1 then acc<=alu_out, ovf|=alu_cf; next SHL.
REQ-018 SHL: alu_op=1001 (SLL), A=mc, B=16'd1; mc<=alu_out; lost|=mc[15]; next SHR.
REQ-019 SHR: alu_op=1011 (SRL), A=mp, B=16'd1; mp<=alu_out; ovf|=(lost_next & alu_out!=0); counter+1; next per REQ-021/REQ-028.
REQ-020 IDLE and DONE: alu_op=0000 (NONE), operands 0; ALU flags ignored.
REQ-021 SHR with counter reaching 16 -> DONE; otherwise -> ADD.
REQ-022 DONE: done=1, product=acc; next IDLE unconditionally.
REQ-023 start while busy (any non-IDLE state, including DONE) SHALL be ignored, not queued.
REQ-024 mcand/mplier changes after accept SHALL not affect the result.
REQ-025 Latency: accept at edge E0; DONE entered after edge E(3n), n = iterations executed; done high that cycle; busy low after E(3n+1).

Reset
REQ-026 rst_n low SHALL immediately force IDLE, acc/mc/mp/counter/lost=0, busy=0, done=0, product=0, ovf=0, alu_op=0000, ALU operands 0, mid-operation included; no done for an aborted operation.
REQ-027 First accept possible on the first rising edge after rst_n deasserts.

Configuration
REQ-028 Macro ALU_MUL_EARLY_EXIT_EN defined: SHR SHALL go to DONE when alu_zf=1 (shifted multiplier zero) or counter reaches 16; n = position of highest set mplier bit + 1, minimum 1.
REQ-029 Macro undefined: alu_zf ignored; n = 16 always (done after E48); results identical in both builds.

Structure
REQ-030 ALU opcode constants (NONE 0000, ADD 0110, SLL 1001, SRL 1011) and the state type SHALL live in a shared package alu_pkg, used by both ALU and alu_mul_seq.
REQ-031 No sub-module; FSM, counter and registers inline; ALU instantiated outside by the integrator.

Verification
REQ-032 Bench SHALL connect alu_mul_seq to the real ALU and cover:
- mcand=3, mplier=5 -> product=0x000F, ovf=0; done after E48 (no macro) or after E9 (macro).
- mcand=0x0100, mplier=0x0100 -> product=0x0000, ovf=1.
- mcand=0xFFFF, mplier=0xFFFF -> product=0x0001, ovf=1; done after E48 in both builds.
- mcand=0x1234, mplier=0 -> product=0, ovf=0; done after E3 (macro) or E48 (no macro).
- start held high through a multiply with new operands -> second request ignored until IDLE, then accepted next edge.
- rst_n low at cycle 20 of mcand=7, mplier=9 -> all outputs 0 immediately, no done; next request 7*9 -> product=0x003F.
